ttw_mem_bridge: RTL and testbench

- Sits directly downstream of the VLB table walker's memory port (mem_req/mem_res) and upstream of the LLC/memory fabric.
- Accepts walker line-fetch requests (walker idx, MCN) and tracks up to N_OUT outstanding fetches in a slot table.
- Issues fetches downstream in arrival order, tagged by slot number, and accepts out-of-order responses.
- Returns each 512-bit line to the walker with its original idx.

---
 rtl/ttw_mem_pkg.sv | 33 +++
 rtl/ttw_mem_fifo.sv | 46 ++++
 rtl/ttw_mem_bridge.sv | 129 ++++++++++++
 tb/tb_ttw_mem_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttw_mem_pkg.sv
// Shared types and width helpers for the table-walker memory bridge.
package ttw_mem_pkg;

  localparam int N_TTW_DEF  = 4;
  localparam int N_OUT_DEF  = 4;
  localparam int MCN_W_DEF  = 58;
  localparam int DATA_W_DEF = 512;

  function automatic int ttw_w_f(input int n_ttw);
    return (n_ttw > 1) ? $clog2(n_ttw) : 1;
  endfunction

  function automatic int tag_w_f(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  localparam int TTW_W_DEF = ttw_w_f(N_TTW_DEF);
  localparam int TAG_W_DEF = tag_w_f(N_OUT_DEF);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } slot_st_e;

  typedef struct packed {
    logic [TTW_W_DEF-1:0]  idx;
    logic [MCN_W_DEF-1:0]  mcn;
    logic [DATA_W_DEF-1:0] data;
  } slot_rec_t;

endpackage

// File: rtl/ttw_mem_fifo.sv
// Issue-order FIFO of slot numbers; depth equals the slot count, so it cannot overflow.
module ttw_mem_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ttw_mem_bridge.sv
// Bridges walker line fetches to the LLC: slot table, in-order issue, out-of-order return.
module ttw_mem_bridge
  import ttw_mem_pkg::*;
#(
  parameter int N_TTW  = N_TTW_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int MCN_W  = MCN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mem_req_i_valid,
  output logic                          mem_req_i_ready,
  input  logic [ttw_w_f(N_TTW)-1:0]     mem_req_i_bits_idx,
  input  logic [MCN_W-1:0]              mem_req_i_bits_mcn,
  output logic                          mem_res_o_valid,
  input  logic                          mem_res_o_ready,
  output logic [ttw_w_f(N_TTW)-1:0]     mem_res_o_bits_idx,
  output logic [DATA_W-1:0]             mem_res_o_bits_data,
  output logic                          llc_req_o_valid,
  input  logic                          llc_req_o_ready,
  output logic [tag_w_f(N_OUT)-1:0]     llc_req_o_bits_tag,
  output logic [MCN_W-1:0]              llc_req_o_bits_mcn,
  input  logic                          llc_res_i_valid,
  input  logic [tag_w_f(N_OUT)-1:0]     llc_res_i_bits_tag,
  input  logic [DATA_W-1:0]             llc_res_i_bits_data,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int TTW_W = ttw_w_f(N_TTW);
  localparam int TAG_W = tag_w_f(N_OUT);

  slot_st_e          st_q [N_OUT];
  slot_st_e          st_d [N_OUT];
  logic [TTW_W-1:0]  idx_q  [N_OUT];
  logic [MCN_W-1:0]  mcn_q  [N_OUT];
  logic [DATA_W-1:0] data_q [N_OUT];

  logic [N_OUT-1:0] free_v, done_v;
  logic [TAG_W-1:0] alloc_tag, done_tag, res_sel, sel_q, issue_tag;
  logic             hold_q, err_q, issue_empty;
  logic             req_fire, llc_fire, res_fire, res_ok;

  function automatic logic [TAG_W-1:0] pick_low(input logic [N_OUT-1:0] v);
    pick_low = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (v[i]) pick_low = i[TAG_W-1:0];
    end
  endfunction

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      free_v[i] = (st_q[i] == FREE);
      done_v[i] = (st_q[i] == DONE);
    end
  end

  assign alloc_tag = pick_low(free_v);
  assign done_tag  = pick_low(done_v);
  // A stalled return keeps its slot even if a lower-index slot completes meanwhile.
  assign res_sel   = hold_q ? sel_q : done_tag;

  assign mem_req_i_ready = |free_v;
  assign busy_o          = ~&free_v;
  assign err_o           = err_q;

  assign llc_req_o_valid = !issue_empty;
  assign mem_res_o_valid = |done_v;

  assign req_fire = mem_req_i_valid && mem_req_i_ready;
  assign llc_fire = llc_req_o_valid && llc_req_o_ready;
  assign res_fire = mem_res_o_valid && mem_res_o_ready;
  assign res_ok   = llc_res_i_valid && (st_q[llc_res_i_bits_tag] == WAIT);

  // Payload outputs are masked so they read zero whenever their valid is low.
  assign llc_req_o_bits_tag  = llc_req_o_valid ? issue_tag : '0;
  assign llc_req_o_bits_mcn  = llc_req_o_valid ? mcn_q[issue_tag] : '0;
  assign mem_res_o_bits_idx  = mem_res_o_valid ? idx_q[res_sel] : '0;
  assign mem_res_o_bits_data = mem_res_o_valid ? data_q[res_sel] : '0;

  ttw_mem_fifo #(
    .DEPTH (N_OUT),
    .W     (TAG_W)
  ) u_issue_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_fire),
    .push_data (alloc_tag),
    .pop       (llc_fire),
    .head      (issue_tag),
    .empty     (issue_empty)
  );

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      st_d[i] = st_q[i];
      if (req_fire && alloc_tag == i[TAG_W-1:0])         st_d[i] = PEND;
      if (llc_fire && issue_tag == i[TAG_W-1:0])         st_d[i] = WAIT;
      if (res_ok && llc_res_i_bits_tag == i[TAG_W-1:0])  st_d[i] = DONE;
      if (res_fire && res_sel == i[TAG_W-1:0])           st_d[i] = FREE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) st_q[i] <= FREE;
      hold_q <= 1'b0;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) st_q[i] <= st_d[i];
      hold_q <= mem_res_o_valid && !mem_res_o_ready;
      sel_q  <= res_sel;
      if (llc_res_i_valid && !res_ok) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_OUT; i++) begin
      if (req_fire && alloc_tag == i[TAG_W-1:0]) begin
        idx_q[i] <= mem_req_i_bits_idx;
        mcn_q[i] <= mem_req_i_bits_mcn;
      end
      if (res_ok && llc_res_i_bits_tag == i[TAG_W-1:0]) data_q[i] <= llc_res_i_bits_data;
    end
  end

endmodule

// File: tb/tb_ttw_mem_bridge.sv
// Directed bench for ttw_mem_bridge: fetch, fill, out-of-order return, ordering, errors, reset.
module tb_ttw_mem_bridge;

  logic         clock = 1'b0;
  logic         reset;
  logic         mem_req_i_valid;
  logic         mem_req_i_ready;
  logic [1:0]   mem_req_i_bits_idx;
  logic [57:0]  mem_req_i_bits_mcn;
  logic         mem_res_o_valid;
  logic         mem_res_o_ready;
  logic [1:0]   mem_res_o_bits_idx;
  logic [511:0] mem_res_o_bits_data;
  logic         llc_req_o_valid;
  logic         llc_req_o_ready;
  logic [1:0]   llc_req_o_bits_tag;
  logic [57:0]  llc_req_o_bits_mcn;
  logic         llc_res_i_valid;
  logic [1:0]   llc_res_i_bits_tag;
  logic [511:0] llc_res_i_bits_data;
  logic         busy_o;
  logic         err_o;

  int total = 0;
  int bad   = 0;

  logic [511:0] d1 = {64{8'hAB}};
  logic [511:0] d2 = {64{8'h22}};
  logic [511:0] da = {16{32'hA5A5_0002}};
  logic [511:0] db = {16{32'h5B5B_0000}};
  logic [511:0] dc = {16{32'hC3C3_0001}};
  logic [511:0] d4 = {64{8'h44}};
  logic [511:0] d5 = {64{8'h55}};
  logic [511:0] d6 = {64{8'h66}};
  logic [511:0] d7 = {64{8'h77}};

  ttw_mem_bridge dut (
    .clock               (clock),
    .reset               (reset),
    .mem_req_i_valid     (mem_req_i_valid),
    .mem_req_i_ready     (mem_req_i_ready),
    .mem_req_i_bits_idx  (mem_req_i_bits_idx),
    .mem_req_i_bits_mcn  (mem_req_i_bits_mcn),
    .mem_res_o_valid     (mem_res_o_valid),
    .mem_res_o_ready     (mem_res_o_ready),
    .mem_res_o_bits_idx  (mem_res_o_bits_idx),
    .mem_res_o_bits_data (mem_res_o_bits_data),
    .llc_req_o_valid     (llc_req_o_valid),
    .llc_req_o_ready     (llc_req_o_ready),
    .llc_req_o_bits_tag  (llc_req_o_bits_tag),
    .llc_req_o_bits_mcn  (llc_req_o_bits_mcn),
    .llc_res_i_valid     (llc_res_i_valid),
    .llc_res_i_bits_tag  (llc_res_i_bits_tag),
    .llc_res_i_bits_data (llc_res_i_bits_data),
    .busy_o              (busy_o),
    .err_o               (err_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic v, input logic [1:0] idx, input logic [57:0] mcn);
    mem_req_i_valid    = v;
    mem_req_i_bits_idx = idx;
    mem_req_i_bits_mcn = mcn;
  endtask

  task automatic llc_res(input logic v, input logic [1:0] tag, input logic [511:0] data);
    llc_res_i_valid     = v;
    llc_res_i_bits_tag  = tag;
    llc_res_i_bits_data = data;
  endtask

  task automatic chk_llc(input string tag, input logic [1:0] etag, input logic [57:0] emcn);
    chk({tag, "_v"}, 512'(llc_req_o_valid), 512'(1));
    chk({tag, "_tag"}, 512'(llc_req_o_bits_tag), 512'(etag));
    chk({tag, "_mcn"}, 512'(llc_req_o_bits_mcn), 512'(emcn));
  endtask

  task automatic chk_res(input string tag, input logic [1:0] eidx, input logic [511:0] edata);
    chk({tag, "_v"}, 512'(mem_res_o_valid), 512'(1));
    chk({tag, "_idx"}, 512'(mem_res_o_bits_idx), 512'(eidx));
    chk({tag, "_data"}, mem_res_o_bits_data, edata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req(1'b0, 2'd0, 58'h0);
    llc_res(1'b0, 2'd0, '0);
    mem_res_o_ready = 1'b0;
    llc_req_o_ready = 1'b0;
    #2;
    chk("rst_llc_v", 512'(llc_req_o_valid), 512'(0));
    chk("rst_res_v", 512'(mem_res_o_valid), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_err", 512'(err_o), 512'(0));
    chk("rst_data", mem_res_o_bits_data, '0);
    tick();
    reset = 1'b0;
    chk("post_rst_ready", 512'(mem_req_i_ready), 512'(1));

    // Single fetch
    req(1'b1, 2'd2, 58'h123);
    llc_req_o_ready = 1'b1;
    mem_res_o_ready = 1'b1;
    tick();
    req(1'b0, 2'd0, 58'h0);
    chk_llc("t1_llc", 2'd0, 58'h123);
    chk("t1_busy", 512'(busy_o), 512'(1));
    tick();
    chk("t1_llc_gone", 512'(llc_req_o_valid), 512'(0));
    tick();
    llc_res(1'b1, 2'd0, d1);
    chk("t1_res_early", 512'(mem_res_o_valid), 512'(0));
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk_res("t1_res", 2'd2, d1);
    tick();
    chk("t1_res_done", 512'(mem_res_o_valid), 512'(0));
    chk("t1_idle", 512'(busy_o), 512'(0));

    // Fill and back-pressure
    llc_req_o_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(1'b1, i[1:0], 58'h10 + 58'(i));
      chk("t2_ready_fill", 512'(mem_req_i_ready), 512'(1));
      tick();
    end
    req(1'b1, 2'd0, 58'h14);
    chk("t2_full", 512'(mem_req_i_ready), 512'(0));
    chk_llc("t2_head", 2'd0, 58'h10);
    llc_req_o_ready = 1'b1;
    tick();
    llc_req_o_ready = 1'b0;
    llc_res(1'b1, 2'd0, d2);
    chk("t2_full_wait", 512'(mem_req_i_ready), 512'(0));
    chk_llc("t2_head1", 2'd1, 58'h11);
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk_res("t2_res", 2'd0, d2);
    chk("t2_full_done", 512'(mem_req_i_ready), 512'(0));
    tick();
    chk("t2_freed", 512'(mem_req_i_ready), 512'(1));
    chk("t2_res_gone", 512'(mem_res_o_valid), 512'(0));
    tick();
    req(1'b0, 2'd0, 58'h0);
    chk("t2_refull", 512'(mem_req_i_ready), 512'(0));
    chk("t2_busy", 512'(busy_o), 512'(1));
    do_reset();

    // Out-of-order return; a stalled return holds its slot
    llc_req_o_ready = 1'b1;
    mem_res_o_ready = 1'b0;
    req(1'b1, 2'd1, 58'h20);
    tick();
    req(1'b1, 2'd2, 58'h21);
    chk_llc("t3_i0", 2'd0, 58'h20);
    tick();
    req(1'b1, 2'd3, 58'h22);
    chk_llc("t3_i1", 2'd1, 58'h21);
    tick();
    req(1'b0, 2'd0, 58'h0);
    chk_llc("t3_i2", 2'd2, 58'h22);
    tick();
    llc_req_o_ready = 1'b0;
    chk("t3_llc_idle", 512'(llc_req_o_valid), 512'(0));
    llc_res(1'b1, 2'd2, da);
    tick();
    llc_res(1'b1, 2'd0, db);
    chk_res("t3_s2", 2'd3, da);
    tick();
    llc_res(1'b1, 2'd1, dc);
    chk_res("t3_s2_hold", 2'd3, da);
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk_res("t3_s2_hold2", 2'd3, da);
    mem_res_o_ready = 1'b1;
    tick();
    chk_res("t3_s0", 2'd1, db);
    tick();
    chk_res("t3_s1", 2'd2, dc);
    tick();
    chk("t3_res_gone", 512'(mem_res_o_valid), 512'(0));
    chk("t3_idle", 512'(busy_o), 512'(0));
    do_reset();

    // Issue ordering: a reused slot queues behind earlier arrivals
    llc_req_o_ready = 1'b0;
    req(1'b1, 2'd0, 58'h30);
    tick();
    req(1'b1, 2'd1, 58'h31);
    tick();
    req(1'b1, 2'd2, 58'h32);
    llc_req_o_ready = 1'b1;
    chk_llc("t4_i0", 2'd0, 58'h30);
    tick();
    req(1'b1, 2'd3, 58'h33);
    chk_llc("t4_i1", 2'd1, 58'h31);
    tick();
    req(1'b0, 2'd0, 58'h0);
    llc_req_o_ready = 1'b0;
    llc_res(1'b1, 2'd1, d2);
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk_res("t4_free1", 2'd1, d2);
    tick();
    req(1'b1, 2'd2, 58'h55);
    chk("t4_ready", 512'(mem_req_i_ready), 512'(1));
    tick();
    req(1'b0, 2'd0, 58'h0);
    llc_req_o_ready = 1'b1;
    chk_llc("t4_o2", 2'd2, 58'h32);
    tick();
    chk_llc("t4_o3", 2'd3, 58'h33);
    tick();
    chk_llc("t4_o1", 2'd1, 58'h55);
    tick();
    llc_req_o_ready = 1'b0;
    chk("t4_llc_idle", 512'(llc_req_o_valid), 512'(0));

    // Spurious response to a FREE slot
    llc_res(1'b1, 2'd3, d4);
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk_res("t5_s3", 2'd3, d4);
    tick();
    llc_res(1'b1, 2'd3, d5);
    chk("t5_err_pre", 512'(err_o), 512'(0));
    chk("t5_ready", 512'(mem_req_i_ready), 512'(1));
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk("t5_err", 512'(err_o), 512'(1));
    chk("t5_no_res", 512'(mem_res_o_valid), 512'(0));
    chk("t5_busy", 512'(busy_o), 512'(1));
    tick();
    chk("t5_err_hold", 512'(err_o), 512'(1));
    llc_res(1'b1, 2'd0, d6);
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk_res("t5_s0", 2'd0, d6);
    tick();

    // Reset in the middle of traffic
    mem_res_o_ready = 1'b0;
    req(1'b1, 2'd3, 58'h60);
    tick();
    req(1'b1, 2'd1, 58'h61);
    llc_req_o_ready = 1'b1;
    chk_llc("t6_i0", 2'd0, 58'h60);
    tick();
    req(1'b0, 2'd0, 58'h0);
    llc_req_o_ready = 1'b0;
    chk_llc("t6_pend3", 2'd3, 58'h61);
    chk("t6_err_pre", 512'(err_o), 512'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("t6_llc_v", 512'(llc_req_o_valid), 512'(0));
    chk("t6_llc_tag", 512'(llc_req_o_bits_tag), 512'(0));
    chk("t6_llc_mcn", 512'(llc_req_o_bits_mcn), 512'(0));
    chk("t6_busy", 512'(busy_o), 512'(0));
    chk("t6_err_clr", 512'(err_o), 512'(0));
    chk("t6_res_v", 512'(mem_res_o_valid), 512'(0));
    tick();
    reset = 1'b0;
    chk("t6_ready", 512'(mem_req_i_ready), 512'(1));
    llc_res(1'b1, 2'd1, d7);
    tick();
    llc_res(1'b0, 2'd0, '0);
    chk("t6_stale_err", 512'(err_o), 512'(1));
    chk("t6_no_res", 512'(mem_res_o_valid), 512'(0));
    chk("t6_idle", 512'(busy_o), 512'(0));
    tick();
    chk("t6_err_hold", 512'(err_o), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
